vid_fetch_sched: RTL
====================

// Module: vid_fetch_sched
// PURPOSE
//  Schedules framebuffer reads for the video pipeline. Tracks sx/sy from the pixel timing generator.
//  On the last active pixel of each line, fetches the next active line into a double-banked line buffer.
//  Shares the single framebuffer memory port with a host requester; display fetch has strict priority.
//  Flags underrun when a fetch has not finished by end of line.
// PARAMETERS
//  WIDTH       10    sx/sy width; selects mode: 10=640x480 (H_ACT 639, H_TOT 799, V_ACT 479, V_TOT 524),
//                    12=1280x720 (1279,1649,719,749), 14=1920x1080 (1919,2199,1079,1124)
//  LINE_WORDS  160   memory words per active line (e.g. 640 px x 8 bpp / 32)
//  AW          18    memory word-address width
//  DW          32    memory data width
//  RD_LAT      2     fixed read latency in cycles (>=1)
// PORTS
//  clk_pix      in   1       pixel clock
//  rst_pix_n    in   1       asynchronous active-low reset
//  en           in   1       1 = allow new fetch triggers
//  sx, sy       in   WIDTH   current pixel position from timing generator
//  fb_base      in   AW      framebuffer base word address, sampled at fetch trigger
//  mem_req      out  1       memory request
//  mem_we       out  1       1 = write (host only)
//  mem_addr     out  AW      word address
//  mem_wdata    out  DW      write data
//  mem_ready    in   1       memory accepts when mem_req && mem_ready
//  mem_rdata    in   DW      read data, valid exactly RD_LAT cycles after accepted read
//  host_req     in   1       host request; held stable until host_gnt
//  host_we      in   1       host write enable
//  host_addr    in   AW      host address
//  host_wdata   in   DW      host write data
//  host_gnt     out  1       host request accepted this cycle
//  host_rvalid  out  1       host read data valid (1 cycle)
//  host_rdata   out  DW      host read data
//  lb_we        out  1       line-buffer write strobe
//  lb_bank      out  1       bank being written; display reads ~lb_bank
//  lb_waddr     out  $clog2(LINE_WORDS)   word index within line
//  lb_wdata     out  DW      line-buffer write data
//  fetch_done   out  1       1-cycle pulse when a line fetch completes
//  underrun     out  1       sticky; set on underrun, cleared only by reset
// BEHAVIOUR
//  Reset (async, rst_pix_n=0): state IDLE, counters 0, lb_bank=0, return pipe cleared.
//   All outputs 0; mem_req/host_gnt forced 0 while in reset.
//  Trigger: cycle with sx==H_ACT && en && state==IDLE && next line active.
//   nl = (sy==V_TOT) ? 0 : sy+1. Next line is active when sy<V_ACT or sy==V_TOT.
//   At the trigger: latch addr0 = fb_base + nl*LINE_WORDS (mod 2^AW), toggle lb_bank, go to FETCH.
//  States:
//   IDLE  -> FETCH on trigger.
//   FETCH: mem_req=1, mem_we=0, mem_addr=addr0+issue_cnt. issue_cnt++ on accept.
//          After the accept with issue_cnt==LINE_WORDS-1, go to DRAIN.
//   DRAIN: no display requests. When ret_cnt==LINE_WORDS, go to IDLE; fetch_done=1 that cycle.
//  Host arbitration (combinational): host drives mem_* when state!=FETCH.
//   host_gnt = host_req && mem_ready && state!=FETCH. Host never preempts FETCH.
//  Return pipe: RD_LAT-deep shift register of {valid, src(disp/host), idx}, loaded on each accepted read.
//   At its output: disp -> lb_we=1, lb_waddr=idx, lb_wdata=mem_rdata, ret_cnt++.
//   host -> host_rvalid=1, host_rdata=mem_rdata. Writes produce no return.
//  Ordering: returns are in issue order; host and display returns may interleave only across the FETCH boundary.
//  Underrun: at sx==H_TOT, if state!=IDLE -> underrun<=1.
//   The fetch continues to completion; triggers while not IDLE are ignored (that line is skipped).
//  en deasserted mid-fetch: the current fetch completes; no new triggers.
//  Wrap: addr0 + idx wraps mod 2^AW. The sy==V_TOT trigger fetches line 0.
// TESTING  (WIDTH=10, LINE_WORDS=160, RD_LAT=2, fb_base=0x1000, mem_ready=1 unless stated; T = trigger cycle)
//  1. sy=0, sx=639 at T -> mem_req T+1..T+160, addr 0x10A0..0x113F, lb_bank=1.
//     160 lb_we T+3..T+162 with lb_waddr 0..159; fetch_done at T+163.
//  2. sy=524, sx=639 -> line 0 fetched, first mem_addr=0x1000, lb_bank toggles.
//  3. sy=479, sx=639 -> no fetch, mem_req stays 0, lb_bank unchanged.
//  4. host read to 0x0005 asserted at T+5 -> host_gnt at T+161 (first DRAIN cycle).
//     host_rvalid at T+163 with the mem_rdata of that cycle.
//  5. mem_ready=0 from T -> at sx=799 underrun=1 and stays 1. The next trigger is ignored.
//     After mem_ready=1 the fetch completes and fetch_done pulses.
//  6. rst_pix_n=0 at T+50 -> same cycle mem_req=0, lb_we=0, underrun=0.
//     After release no request until the next valid trigger; that trigger sets lb_bank=1.

Source files
------------

// File: rtl/vid_fetch_sched_if.sv
// Framebuffer memory port shared by the display fetch and the host.
// master = scheduler side, slave = memory side.
interface vid_fetch_sched_if #(
  parameter int unsigned AW = 18,
  parameter int unsigned DW = 32
) ();
  logic          mem_req;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          mem_ready;
  logic [DW-1:0] mem_rdata;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_ready, mem_rdata
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output mem_ready, mem_rdata
  );
endinterface

// File: rtl/vid_fetch_sched.sv
// Line fetch scheduler: prefetches the next active line into a double-banked
// line buffer and lends the framebuffer port to the host outside fetch bursts.
module vid_fetch_sched #(
  parameter int unsigned WIDTH      = 10,
  parameter int unsigned LINE_WORDS = 160,
  parameter int unsigned AW         = 18,
  parameter int unsigned DW         = 32,
  parameter int unsigned RD_LAT     = 2
) (
  input  logic                          clk_pix,
  input  logic                          rst_pix_n,
  input  logic                          en,
  input  logic [WIDTH-1:0]              sx,
  input  logic [WIDTH-1:0]              sy,
  input  logic [AW-1:0]                 fb_base,
  vid_fetch_sched_if.master             mem,
  input  logic                          host_req,
  input  logic                          host_we,
  input  logic [AW-1:0]                 host_addr,
  input  logic [DW-1:0]                 host_wdata,
  output logic                          host_gnt,
  output logic                          host_rvalid,
  output logic [DW-1:0]                 host_rdata,
  output logic                          lb_we,
  output logic                          lb_bank,
  output logic [$clog2(LINE_WORDS)-1:0] lb_waddr,
  output logic [DW-1:0]                 lb_wdata,
  output logic                          fetch_done,
  output logic                          underrun
);

  localparam int unsigned IW = $clog2(LINE_WORDS);
  localparam int unsigned CW = $clog2(LINE_WORDS + 1);

  // Video mode timing selected by the coordinate width
  localparam int unsigned H_ACT = (WIDTH == 14) ? 1919 : (WIDTH == 12) ? 1279 : 639;
  localparam int unsigned H_TOT = (WIDTH == 14) ? 2199 : (WIDTH == 12) ? 1649 : 799;
  localparam int unsigned V_ACT = (WIDTH == 14) ? 1079 : (WIDTH == 12) ? 719  : 479;
  localparam int unsigned V_TOT = (WIDTH == 14) ? 1124 : (WIDTH == 12) ? 749  : 524;

  typedef enum logic [1:0] {IDLE, FETCH, DRAIN} state_t;

  typedef struct packed {
    logic          valid;
    logic          host;
    logic [IW-1:0] idx;
  } ret_t;

  state_t        state;
  logic [AW-1:0] addr0;
  logic [IW-1:0] issue_cnt;
  logic [CW-1:0] ret_cnt;
  ret_t          ret_pipe [RD_LAT];

  logic [WIDTH-1:0] nl_c;
  logic             nl_act_c;
  logic             trig_c;
  logic             fetching_c;
  logic             host_sel_c;
  logic             disp_acc_c;
  logic             host_rd_acc_c;
  ret_t             ret_in_c;
  ret_t             ret_out_c;

  // Trigger decode and port arbitration; display fetch always wins the port
  always_comb begin
    nl_c          = (sy == WIDTH'(V_TOT)) ? '0 : sy + WIDTH'(1);
    nl_act_c      = (sy < WIDTH'(V_ACT)) || (sy == WIDTH'(V_TOT));
    trig_c        = (sx == WIDTH'(H_ACT)) && en && (state == IDLE) && nl_act_c;
    fetching_c    = (state == FETCH);
    host_sel_c    = rst_pix_n && !fetching_c;
    host_gnt      = host_sel_c && host_req && mem.mem_ready;
    disp_acc_c    = fetching_c && mem.mem_ready;
    host_rd_acc_c = host_gnt && !host_we;

    mem.mem_req   = rst_pix_n && (fetching_c || host_req);
    mem.mem_we    = host_sel_c && host_req && host_we;
    mem.mem_addr  = fetching_c ? addr0 + AW'(issue_cnt)
                  : (host_sel_c ? host_addr : '0);
    mem.mem_wdata = host_sel_c ? host_wdata : '0;

    ret_in_c       = '0;
    ret_in_c.valid = disp_acc_c || host_rd_acc_c;
    ret_in_c.host  = host_rd_acc_c;
    ret_in_c.idx   = disp_acc_c ? issue_cnt : '0;
  end

  // Read returns are steered by the tag that travelled with the request
  always_comb begin
    ret_out_c   = ret_pipe[RD_LAT-1];
    lb_we       = ret_out_c.valid && !ret_out_c.host;
    lb_waddr    = lb_we ? ret_out_c.idx : '0;
    lb_wdata    = lb_we ? mem.mem_rdata : '0;
    host_rvalid = ret_out_c.valid && ret_out_c.host;
    host_rdata  = host_rvalid ? mem.mem_rdata : '0;
    fetch_done  = (state == DRAIN) && (ret_cnt == CW'(LINE_WORDS));
  end

  always_ff @(posedge clk_pix or negedge rst_pix_n) begin
    if (!rst_pix_n) begin
      state     <= IDLE;
      addr0     <= '0;
      issue_cnt <= '0;
      ret_cnt   <= '0;
      lb_bank   <= 1'b0;
      underrun  <= 1'b0;
      for (int i = 0; i < int'(RD_LAT); i++) ret_pipe[i] <= '0;
    end else begin
      ret_pipe[0] <= ret_in_c;
      for (int i = 1; i < int'(RD_LAT); i++) ret_pipe[i] <= ret_pipe[i-1];

      if (lb_we) ret_cnt <= ret_cnt + CW'(1);

      // A fetch still in flight at end of line means this line missed its data
      if ((sx == WIDTH'(H_TOT)) && (state != IDLE)) underrun <= 1'b1;

      case (state)
        IDLE: begin
          if (trig_c) begin
            addr0     <= fb_base + AW'(nl_c) * AW'(LINE_WORDS);
            lb_bank   <= ~lb_bank;
            issue_cnt <= '0;
            ret_cnt   <= '0;
            state     <= FETCH;
          end
        end
        FETCH: begin
          if (disp_acc_c) begin
            issue_cnt <= issue_cnt + IW'(1);
            if (issue_cnt == IW'(LINE_WORDS - 1)) state <= DRAIN;
          end
        end
        DRAIN: begin
          if (fetch_done) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
